// File: rtl/usb_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usb_cmd_ctrl
//  Description : Command sequencer on the USB clock domain. Decodes host
//                commands from the USB bridge, holds the acquisition
//                configuration register file, starts/stops acquisition while
//                counting completed frames, and emits fixed 4-word reply
//                frames (HDR, {cmd,status}, data[31:16], data[15:0]) into a
//                16-bit upload write port with a full flag.
//
//  Ports       : i_clk_usb       USB interface clock
//                i_rst_n         asynchronous active-low reset
//                i_cmd_come      one-cycle command strobe
//                i_cmd           command code (8)
//                i_cmd_param     command parameter (32)
//                i_frame_done    per-frame completion pulse
//                i_tx_full       upload port full
//                o_tx_wr         upload write strobe
//                o_tx_data       upload write data (16)
//                o_cfg           flattened register file, reg k at [16k+:16]
//                o_acq_start     one-cycle acquisition start pulse
//                o_acq_run       acquisition active level
//                o_acq_done      one-cycle programmed-count-complete pulse
//                o_busy          sequencer not idle
//                o_drop_cnt      saturating count of dropped commands (8)
//
//  Options     : USB_CMD_ACK_EN  when defined every command produces a reply
//                                frame; otherwise only READ_REG and commands
//                                with non-zero status reply.
//
//  Revision    : 1.0  initial release
// ============================================================================
module usb_cmd_ctrl #(
   parameter int          NREG   = 8,
   parameter int          ADDR_W = 3,
   parameter logic [15:0] HDR    = 16'hA55A
) (
   input  logic                 i_clk_usb,
   input  logic                 i_rst_n,
   input  logic                 i_cmd_come,
   input  logic [7:0]           i_cmd,
   input  logic [31:0]          i_cmd_param,
   input  logic                 i_frame_done,
   input  logic                 i_tx_full,
   output logic                 o_tx_wr,
   output logic [15:0]          o_tx_data,
   output logic [16*NREG-1:0]   o_cfg,
   output logic                 o_acq_start,
   output logic                 o_acq_run,
   output logic                 o_acq_done,
   output logic                 o_busy,
   output logic [7:0]           o_drop_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_TX   = 2'd2
   } state_t;

   localparam logic [7:0]  c_cmd_write = 8'h01;
   localparam logic [7:0]  c_cmd_read  = 8'h02;
   localparam logic [7:0]  c_cmd_start = 8'h03;
   localparam logic [7:0]  c_cmd_stop  = 8'h04;
   localparam logic [7:0]  c_cmd_clr   = 8'h05;
   localparam logic [15:0] c_nreg      = 16'(NREG);

   state_t        state_q,     state_d;
   logic [7:0]    cmd_q,       cmd_d;
   logic [31:0]   param_q,     param_d;
   logic [7:0]    status_q,    status_d;
   logic [31:0]   data_q,      data_d;
   logic [1:0]    widx_q,      widx_d;
   logic [15:0]   tx_data_q,   tx_data_d;
   logic [15:0]   cfg_q [NREG];
   logic [15:0]   cfg_d [NREG];
   logic [31:0]   remaining_q, remaining_d;
   logic [31:0]   done_cnt_q,  done_cnt_d;
   logic          acq_run_q,   acq_run_d;
   logic          acq_start_q, acq_start_d;
   logic          acq_done_q,  acq_done_d;
   logic [7:0]    drop_cnt_q,  drop_cnt_d;

   // The full upper parameter half is the address for range checking and
   // reply data; only its low ADDR_W bits index the register file.
   logic [15:0]        addr16;
   logic [15:0]        value;
   logic [ADDR_W-1:0]  addr_idx;
   logic               addr_ok;
   logic               frame_evt;
   logic               tx_accept;
   logic               reply;

   assign addr16    = param_q[31:16];
   assign value     = param_q[15:0];
   assign addr_idx  = param_q[16 +: ADDR_W];
   assign addr_ok   = (addr16 < c_nreg);
   assign frame_evt = i_frame_done & acq_run_q;
   // Write strobe is combinational so it can honour i_tx_full in the same
   // cycle; the word itself comes straight from a register.
   assign tx_accept = (state_q == ST_TX) & ~i_tx_full;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      param_d     = param_q;
      status_d    = status_q;
      data_d      = data_q;
      widx_d      = widx_q;
      tx_data_d   = tx_data_q;
      cfg_d       = cfg_q;
      remaining_d = remaining_q;
      done_cnt_d  = done_cnt_q;
      acq_run_d   = acq_run_q;
      acq_start_d = 1'b0;
      acq_done_d  = 1'b0;
      drop_cnt_d  = drop_cnt_q;
      reply       = 1'b0;

      // Frame accounting runs in every state; START/STOP in EXEC below
      // override the run/remaining/done results of a coincident frame.
      if (frame_evt) begin
         done_cnt_d = done_cnt_q + 32'd1;
         if (remaining_q != 32'd0) begin
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
               acq_run_d  = 1'b0;
               acq_done_d = 1'b1;
            end
         end
      end

      if (i_cmd_come && (state_q != ST_IDLE) && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_cmd_come) begin
               cmd_d   = i_cmd;
               param_d = i_cmd_param;
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            status_d = 8'h00;
            data_d   = 32'h0;
            case (cmd_q)
               c_cmd_write: begin
                  data_d = {addr16, value};
                  if (addr_ok) begin
                     cfg_d[addr_idx] = value;
                  end else begin
                     status_d = 8'h01;
                  end
               end
               c_cmd_read: begin
                  if (addr_ok) begin
                     data_d = {16'h0, cfg_q[addr_idx]};
                  end else begin
                     status_d = 8'h01;
                  end
               end
               c_cmd_start: begin
                  remaining_d = param_q;
                  acq_run_d   = 1'b1;
                  acq_start_d = 1'b1;
                  acq_done_d  = 1'b0;
                  done_cnt_d  = 32'd0;
                  data_d      = param_q;
               end
               c_cmd_stop: begin
                  acq_run_d   = 1'b0;
                  remaining_d = 32'd0;
                  acq_done_d  = 1'b0;
                  // Includes a frame completing on this very edge.
                  data_d      = done_cnt_d;
               end
               c_cmd_clr: begin
                  drop_cnt_d = 8'd0;
               end
               default: begin
                  status_d = 8'h02;
               end
            endcase

`ifdef USB_CMD_ACK_EN
            reply = 1'b1;
`else
            reply = (cmd_q == c_cmd_read) || (status_d != 8'h00);
`endif
            if (reply) begin
               state_d   = ST_TX;
               widx_d    = 2'd0;
               tx_data_d = HDR;
            end else begin
               state_d   = ST_IDLE;
            end
         end

         ST_TX: begin
            // Index and word only move on an accepted write, so a full
            // upload port stalls with o_tx_data held.
            if (tx_accept) begin
               widx_d = widx_q + 2'd1;
               case (widx_q)
                  2'd0:    tx_data_d = {cmd_q, status_q};
                  2'd1:    tx_data_d = data_q[31:16];
                  2'd2:    tx_data_d = data_q[15:0];
                  default: state_d   = ST_IDLE;
               endcase
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cmd_q       <= 8'h0;
         param_q     <= 32'h0;
         status_q    <= 8'h0;
         data_q      <= 32'h0;
         widx_q      <= 2'd0;
         tx_data_q   <= 16'h0;
         cfg_q       <= '{default: '0};
         remaining_q <= 32'h0;
         done_cnt_q  <= 32'h0;
         acq_run_q   <= 1'b0;
         acq_start_q <= 1'b0;
         acq_done_q  <= 1'b0;
         drop_cnt_q  <= 8'h0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         param_q     <= param_d;
         status_q    <= status_d;
         data_q      <= data_d;
         widx_q      <= widx_d;
         tx_data_q   <= tx_data_d;
         cfg_q       <= cfg_d;
         remaining_q <= remaining_d;
         done_cnt_q  <= done_cnt_d;
         acq_run_q   <= acq_run_d;
         acq_start_q <= acq_start_d;
         acq_done_q  <= acq_done_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   generate
      for (genvar k = 0; k < NREG; k++) begin : g_cfg
         assign o_cfg[16*k +: 16] = cfg_q[k];
      end
   endgenerate

   assign o_tx_wr     = tx_accept;
   assign o_tx_data   = tx_data_q;
   assign o_acq_start = acq_start_q;
   assign o_acq_run   = acq_run_q;
   assign o_acq_done  = acq_done_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_cmd_ctrl
//  Description : Directed self-checking bench for usb_cmd_ctrl. Expected
//                reply words and status levels are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usb_cmd_ctrl;

`ifdef USB_CMD_ACK_EN
   localparam int ACK_N = 4;
`else
   localparam int ACK_N = 0;
`endif

   logic          clk;
   logic          rst_n;
   logic          cmd_come;
   logic [7:0]    cmd;
   logic [31:0]   cmd_param;
   logic          frame_done;
   logic          tx_full;
   logic          tx_wr;
   logic [15:0]   tx_data;
   logic [127:0]  cfg;
   logic          acq_start;
   logic          acq_run;
   logic          acq_done;
   logic          busy;
   logic [7:0]    drop_cnt;

   int            n_chk;
   int            n_pass;
   int            n_start;
   int            n_done;
   logic [15:0]   wlog [$];

   usb_cmd_ctrl #(.NREG(8), .ADDR_W(3), .HDR(16'hA55A)) dut (
      .i_clk_usb    (clk),
      .i_rst_n      (rst_n),
      .i_cmd_come   (cmd_come),
      .i_cmd        (cmd),
      .i_cmd_param  (cmd_param),
      .i_frame_done (frame_done),
      .i_tx_full    (tx_full),
      .o_tx_wr      (tx_wr),
      .o_tx_data    (tx_data),
      .o_cfg        (cfg),
      .o_acq_start  (acq_start),
      .o_acq_run    (acq_run),
      .o_acq_done   (acq_done),
      .o_busy       (busy),
      .o_drop_cnt   (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change at posedge+1; everything observed here on the negedge.
   initial begin
      n_start = 0;
      n_done  = 0;
      forever begin
         @(negedge clk);
         if (tx_wr)     wlog.push_back(tx_data);
         if (acq_start) n_start++;
         if (acq_done)  n_done++;
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] c, input logic [31:0] p);
      cmd       = c;
      cmd_param = p;
      cmd_come  = 1'b1;
      tick;
      cmd_come  = 1'b0;
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         tick;
      end
      chk("idle_timeout", {127'h0, busy}, 128'h0);
      tick;
   endtask

   function automatic logic [15:0] wget(input int i);
      if (i < wlog.size()) return wlog[i];
      return 16'hxxxx;
   endfunction

   task automatic chk_reply(input string tag, input int base,
                            input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
      chk({tag, "_nwr"}, 128'(wlog.size() - base), 128'd4);
      chk({tag, "_w0"},  {112'h0, wget(base)},     {112'h0, 16'hA55A});
      chk({tag, "_w1"},  {112'h0, wget(base + 1)}, {112'h0, w1});
      chk({tag, "_w2"},  {112'h0, wget(base + 2)}, {112'h0, w2});
      chk({tag, "_w3"},  {112'h0, wget(base + 3)}, {112'h0, w3});
   endtask

   task automatic frame;
      frame_done = 1'b1;
      tick;
      frame_done = 1'b0;
      tick;
   endtask

   initial begin
      int  b;
      int  bs;
      int  bd;
      bit  stable;

      n_chk      = 0;
      n_pass     = 0;
      rst_n      = 1'b0;
      cmd_come   = 1'b0;
      cmd        = 8'h0;
      cmd_param  = 32'h0;
      frame_done = 1'b0;
      tx_full    = 1'b0;
      repeat (3) tick;

      chk("rst_busy",  {127'h0, busy},    128'h0);
      chk("rst_tx_wr", {127'h0, tx_wr},   128'h0);
      chk("rst_cfg",   cfg,               128'h0);
      chk("rst_run",   {127'h0, acq_run}, 128'h0);
      chk("rst_drop",  {120'h0, drop_cnt}, 128'h0);
      rst_n = 1'b1;
      tick;

      // WRITE_REG reg3 <= 0x1234, then read it back
      b = wlog.size();
      send_cmd(8'h01, 32'h0003_1234);
      wait_idle;
      chk("wr_cfg3", {112'h0, cfg[63:48]}, {112'h0, 16'h1234});
`ifdef USB_CMD_ACK_EN
      chk_reply("wr_ok", b, 16'h0100, 16'h0003, 16'h1234);
`else
      chk("wr_norep", 128'(wlog.size() - b), 128'd0);
`endif

      b = wlog.size();
      send_cmd(8'h02, 32'h0003_0000);
      wait_idle;
      chk_reply("rd3", b, 16'h0200, 16'h0000, 16'h1234);

      // Out-of-range write: no change, error reply in both builds
      b = wlog.size();
      send_cmd(8'h01, 32'h0009_FFFF);
      wait_idle;
      chk("wr_bad_cfg", cfg, 128'h0000_0000_0000_0000_1234_0000_0000_0000);
      chk_reply("wr_bad", b, 16'h0101, 16'h0009, 16'hFFFF);

      b = wlog.size();
      send_cmd(8'h02, 32'h0009_0000);
      wait_idle;
      chk_reply("rd_bad", b, 16'h0201, 16'h0000, 16'h0000);

      // START 3 frames
      bs = n_start;
      bd = n_done;
      b  = wlog.size();
      send_cmd(8'h03, 32'd3);
      wait_idle;
      chk("st3_rep",   128'(wlog.size() - b), 128'(ACK_N));
      chk("st3_start", 128'(n_start - bs), 128'd1);
      chk("st3_run",   {127'h0, acq_run}, 128'h1);
      frame;
      frame;
      chk("f2_run",  {127'h0, acq_run}, 128'h1);
      chk("f2_done", 128'(n_done - bd), 128'd0);
      frame;
      chk("f3_run",  {127'h0, acq_run}, 128'h0);
      chk("f3_done", 128'(n_done - bd), 128'd1);
      frame;
      chk("f4_run",  {127'h0, acq_run}, 128'h0);
      chk("f4_done", 128'(n_done - bd), 128'd1);

      // Continuous START, 5 frames, STOP
      bs = n_start;
      bd = n_done;
      send_cmd(8'h03, 32'd0);
      wait_idle;
      chk("st0_start", 128'(n_start - bs), 128'd1);
      repeat (5) frame;
      chk("st0_run", {127'h0, acq_run}, 128'h1);
      b = wlog.size();
      send_cmd(8'h04, 32'd0);
      wait_idle;
      chk("stop_run",  {127'h0, acq_run}, 128'h0);
      chk("stop_done", 128'(n_done - bd), 128'd0);
`ifdef USB_CMD_ACK_EN
      chk_reply("stop", b, 16'h0400, 16'h0000, 16'h0005);
`else
      chk("stop_norep", 128'(wlog.size() - b), 128'd0);
`endif

      // READ stalled by a full upload port after the header word
      b = wlog.size();
      send_cmd(8'h02, 32'h0003_0000);
      tick;
      tick;
      tx_full = 1'b1;
      stable  = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (tx_data !== 16'h0200 || busy !== 1'b1 || tx_wr !== 1'b0) stable = 1'b0;
      end
      chk("stall_hold", {127'h0, stable}, 128'h1);
      chk("stall_nwr",  128'(wlog.size() - b), 128'd1);
      tick;
      tx_full = 1'b0;
      wait_idle;
      chk_reply("stall", b, 16'h0200, 16'h0000, 16'h1234);

      // Three strobes while busy, the last on the TX-finishing edge
      b = wlog.size();
      send_cmd(8'h02, 32'h0003_0000);
      cmd       = 8'h05;
      cmd_param = 32'h0;
      repeat (3) begin
         cmd_come = 1'b1;
         tick;
         cmd_come = 1'b0;
         tick;
      end
      wait_idle;
      chk("drop3", {120'h0, drop_cnt}, 128'd3);
      chk_reply("drop_rd", b, 16'h0200, 16'h0000, 16'h1234);
      send_cmd(8'h05, 32'h0);
      wait_idle;
      chk("drop_clr", {120'h0, drop_cnt}, 128'd0);

      // Unknown command
      b = wlog.size();
      send_cmd(8'h7E, 32'h1234_5678);
      wait_idle;
      chk_reply("unk", b, 16'h7E02, 16'h0000, 16'h0000);

      // Asynchronous reset in the middle of a reply frame
      send_cmd(8'h02, 32'h0003_0000);
      tick;
      tick;
      chk("pre_rst_busy", {127'h0, busy}, 128'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {127'h0, tx_wr | busy}, 128'h0);
      chk("arst_cfg",  cfg, 128'h0);
      chk("arst_data", {112'h0, tx_data}, 128'h0);
      tick;
      rst_n = 1'b1;
      tick;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
